// File: rtl/simon_game_param.sv
// Simon Says core: an LFSR feeds a growing button sequence that is played on one-hot LEDs and then checked against the player's presses.
// Optional input timeout in WAIT_IN is compiled in with `define SIMON_TIMEOUT_EN.
module simon_game_param #(
    parameter int          N_BUTTONS      = 4,
    parameter int          MAX_LEVEL      = 8,
    parameter int          SHOW_CYCLES    = 4,
    parameter int          GAP_CYCLES     = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          TIMEOUT_CYCLES = 64,
    localparam int         SW             = $clog2(MAX_LEVEL + 1),
    localparam int         EW             = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    input  logic [N_BUTTONS-1:0] in,
    output logic [N_BUTTONS-1:0] led_out,
    output logic                 green,
    output logic                 blue,
    output logic [SW-1:0]        score,
    output logic [EW-1:0]        exp_idx
);

    localparam int IDXW = (N_BUTTONS > 2) ? $clog2(N_BUTTONS) : 1;
    localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [IDXW:0] NB = (IDXW + 1)'(N_BUTTONS);
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_FAIL
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [EW-1:0]       pidx_reg, pidx_next;
    logic [EW-1:0]       exp_idx_reg, exp_idx_next;
    logic [SW-1:0]       level_reg, level_next;
    logic [SW-1:0]       score_reg, score_next;
    logic [15:0]         lfsr_reg;
    logic [N_BUTTONS-1:0] prev_in_reg;
    logic [IDXW-1:0]     seq_reg [MAX_LEVEL];

    logic                seq_we;
    logic [EW-1:0]       seq_waddr;
    logic [IDXW:0]       v_ext;
    logic [IDXW-1:0]     elem;
    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] expected_oh;
    logic [N_BUTTONS-1:0] play_oh;
    logic                pidx_is_last;
    logic                exp_is_last;

`ifdef SIMON_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmr_reg, tmr_next;
`endif

    function automatic logic [N_BUTTONS-1:0] onehot(input logic [IDXW-1:0] idx);
        onehot = N_BUTTONS'(1) << idx;
    endfunction

    // Fold out-of-range LFSR values back into 0..N_BUTTONS-1
    assign v_ext        = {1'b0, lfsr_reg[IDXW-1:0]};
    assign elem         = (v_ext >= NB) ? (v_ext[IDXW-1:0] - NB[IDXW-1:0]) : v_ext[IDXW-1:0];
    assign rise         = in & ~prev_in_reg;
    assign expected_oh  = onehot(seq_reg[exp_idx_reg]);
    assign play_oh      = onehot(seq_reg[pidx_reg]);
    assign pidx_is_last = (SW'(pidx_reg) == level_reg - SW'(1));
    assign exp_is_last  = (SW'(exp_idx_reg) == level_reg - SW'(1));
    assign score        = score_reg;
    assign exp_idx      = exp_idx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            pidx_reg    <= '0;
            exp_idx_reg <= '0;
            level_reg   <= '0;
            score_reg   <= '0;
            lfsr_reg    <= LFSR_SEED;
            prev_in_reg <= '0;
`ifdef SIMON_TIMEOUT_EN
            tmr_reg     <= '0;
`endif
        end else begin
            prev_in_reg <= in;
            if (en) begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                pidx_reg    <= pidx_next;
                exp_idx_reg <= exp_idx_next;
                level_reg   <= level_next;
                score_reg   <= score_next;
                lfsr_reg    <= lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);
`ifdef SIMON_TIMEOUT_EN
                tmr_reg     <= tmr_next;
`endif
            end
        end
    end

    // Sequence store is deliberately not reset; only entries below level are ever read
    always_ff @(posedge clk) begin
        if (!rst && seq_we) begin
            seq_reg[seq_waddr] <= elem;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pidx_next    = pidx_reg;
        exp_idx_next = exp_idx_reg;
        level_next   = level_reg;
        score_next   = score_reg;
        seq_we       = 1'b0;
        seq_waddr    = '0;
`ifdef SIMON_TIMEOUT_EN
        tmr_next     = tmr_reg;
`endif
        if (en) begin
            case (state_reg)
                S_IDLE, S_WIN, S_FAIL: begin
                    if (start) begin
                        seq_we       = 1'b1;
                        seq_waddr    = '0;
                        level_next   = SW'(1);
                        score_next   = '0;
                        exp_idx_next = '0;
                        pidx_next    = '0;
                        cnt_next     = '0;
                        state_next   = S_SHOW_ON;
                    end
                end
                S_SHOW_ON: begin
                    if (cnt_reg == CW'(SHOW_CYCLES - 1)) begin
                        cnt_next   = '0;
                        state_next = S_SHOW_OFF;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
                        cnt_next = '0;
                        if (pidx_is_last) begin
                            pidx_next    = '0;
                            exp_idx_next = '0;
                            state_next   = S_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
                            tmr_next     = '0;
`endif
                        end else begin
                            pidx_next  = pidx_reg + EW'(1);
                            state_next = S_SHOW_ON;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_WAIT_IN: begin
                    // A multi-bit rise can never equal a one-hot pattern, so one compare covers both fail cases
                    if (rise != '0) begin
`ifdef SIMON_TIMEOUT_EN
                        tmr_next = '0;
`endif
                        if (rise != expected_oh) begin
                            state_next = S_FAIL;
                        end else if (!exp_is_last) begin
                            exp_idx_next = exp_idx_reg + EW'(1);
                        end else begin
                            score_next = level_reg;
                            if (level_reg == SW'(MAX_LEVEL)) begin
                                state_next = S_WIN;
                            end else begin
                                seq_we     = 1'b1;
                                seq_waddr  = EW'(level_reg);
                                level_next = level_reg + SW'(1);
                                pidx_next  = '0;
                                cnt_next   = '0;
                                state_next = S_SHOW_ON;
                            end
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (tmr_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_next = S_FAIL;
                    end else begin
                        tmr_next = tmr_reg + TW'(1);
                    end
`endif
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        led_out = '0;
        green   = 1'b0;
        blue    = 1'b0;
        case (state_reg)
            S_SHOW_ON: led_out = play_oh;
            S_WAIT_IN: led_out = in;
            S_WIN: begin
                green   = 1'b1;
                led_out = '1;
            end
            S_FAIL:  blue = 1'b1;
            default: led_out = '0;
        endcase
    end

endmodule

// File: tb/tb_simon_game_param.sv
// Directed bench for simon_game_param (4 buttons, 3 levels, 4 lit / 2 dark cycles).
// Expected sequence elements come from an independent LFSR reference model.
module tb_simon_game_param;

    logic       clk = 1'b0;
    logic       rst, start, en;
    logic [3:0] in_b;
    logic [3:0] led_out;
    logic       green, blue;
    logic [1:0] score;
    logic [1:0] exp_idx;

    int ncmp = 0;
    int nerr = 0;
    int seq_m [3];
    logic [15:0] lfsr_m;

    simon_game_param #(
        .N_BUTTONS(4), .MAX_LEVEL(3), .SHOW_CYCLES(4), .GAP_CYCLES(2),
        .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .in(in_b),
        .led_out(led_out), .green(green), .blue(blue),
        .score(score), .exp_idx(exp_idx)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, taps 16'hB400
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else if (en) lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic begin_game();
        seq_m[0] = int'(lfsr_m[1:0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("new_game_score", 32'(score), 0);
        $display("start game: first element %0d", seq_m[0]);
    endtask

    task automatic play(input int lvl);
        for (int i = 0; i < lvl; i++) begin
            for (int c = 0; c < 4; c++) begin
                chk("show_lit", 32'(led_out), 32'(4'b0001 << seq_m[i]));
                tick();
            end
            for (int g = 0; g < 2; g++) begin
                chk("show_gap", 32'(led_out), 0);
                tick();
            end
        end
        chk("wait_exp_idx", 32'(exp_idx), 0);
        $display("played level %0d", lvl);
    endtask

    task automatic press_mid(input int b, input int exp_after);
        in_b = 4'b0001 << b;
        #1 chk("press_feedback", 32'(led_out), 32'(in_b));
        tick();
        in_b = 4'h0;
        chk("exp_idx_step", 32'(exp_idx), 32'(exp_after));
        tick();
        $display("press %0d -> exp_idx %0d", b, exp_idx);
    endtask

    task automatic press_last(input int b, input int lvl);
        if (lvl < 3) seq_m[lvl] = int'(lfsr_m[1:0]);
        in_b = 4'b0001 << b;
        #1 chk("press_feedback", 32'(led_out), 32'(in_b));
        tick();
        in_b = 4'h0;
        chk("score_step", 32'(score), 32'(lvl));
        $display("level %0d complete, score %0d", lvl, score);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; en = 1'b1; in_b = 4'hF;
        tick(); tick();
        chk("rst_led", 32'(led_out), 0);
        chk("rst_green", 32'(green), 0);
        chk("rst_blue", 32'(blue), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_exp_idx", 32'(exp_idx), 0);
        rst = 1'b0; start = 1'b0; in_b = 4'h0;
        tick(); tick();
        chk("idle_led", 32'(led_out), 0);
        chk("idle_score", 32'(score), 0);
        $display("reset done");

        // Full win
        begin_game();
        play(1);
        press_last(seq_m[0], 1);
        play(2);
        press_mid(seq_m[0], 1);
        press_last(seq_m[1], 2);
        play(3);
        press_mid(seq_m[0], 1);
        press_mid(seq_m[1], 2);
        press_last(seq_m[2], 3);
        chk("win_green", 32'(green), 1);
        chk("win_blue", 32'(blue), 0);
        chk("win_led", 32'(led_out), 32'hF);
        $display("win reached");

        // Wrong press at level 2
        begin_game();
        chk("restart_green", 32'(green), 0);
        play(1);
        press_last(seq_m[0], 1);
        play(2);
        press_mid(seq_m[0], 1);
        in_b = 4'b0001 << ((seq_m[1] + 1) % 4);
        tick();
        in_b = 4'h0;
        chk("wrong_blue", 32'(blue), 1);
        chk("wrong_green", 32'(green), 0);
        chk("wrong_score", 32'(score), 1);
        chk("wrong_led", 32'(led_out), 0);
        tick();
        $display("wrong press -> fail");

        // Two buttons rising together at level 1
        begin_game();
        play(1);
        in_b = (4'b0001 << seq_m[0]) | (4'b0001 << ((seq_m[0] + 1) % 4));
        tick();
        in_b = 4'h0;
        chk("dual_blue", 32'(blue), 1);
        chk("dual_score", 32'(score), 0);
        tick();
        $display("dual press -> fail");

        // Freeze mid SHOW_ON, then reset from WAIT_IN
        begin_game();
        chk("frz_lit0", 32'(led_out), 32'(4'b0001 << seq_m[0]));
        tick();
        chk("frz_lit1", 32'(led_out), 32'(4'b0001 << seq_m[0]));
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("frz_hold", 32'(led_out), 32'(4'b0001 << seq_m[0]));
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("frz_resume_lit", 32'(led_out), 32'(4'b0001 << seq_m[0]));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            chk("frz_resume_gap", 32'(led_out), 0);
            tick();
        end
        chk("frz_wait_exp_idx", 32'(exp_idx), 0);
        $display("freeze resumed with remaining count");
        press_last(seq_m[0], 1);
        play(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_score", 32'(score), 0);
        chk("mrst_led", 32'(led_out), 0);
        chk("mrst_blue", 32'(blue), 0);
        chk("mrst_green", 32'(green), 0);
        in_b = 4'h1;
        tick();
        in_b = 4'h0;
        chk("idle_press_led", 32'(led_out), 0);
        chk("idle_press_blue", 32'(blue), 0);
        $display("mid-game reset -> idle");

`ifdef SIMON_TIMEOUT_EN
        begin_game();
        play(1);
        repeat (7) tick();
        chk("timeout_early", 32'(blue), 0);
        tick();
        chk("timeout_fail", 32'(blue), 1);
        $display("timeout -> fail");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
